// File: rtl/seq_detect_param.sv
// Serial pattern detector: latches a word on start, scans it MSB-first one bit per clock,
// counts (optionally overlapping) matches of PATTERN and records where the first one completes.
module seq_detect_param #(
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 4,
  localparam int              IDX_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CNT_W-1:0]  match_count,
  output logic [IDX_W-1:0]  first_pos
);

  localparam int FIL_W = $clog2(PAT_W + 1);

  if (DATA_W < 2 || PAT_W < 1 || PAT_W > DATA_W || CNT_W < 1) begin : g_param_check
    $error("seq_detect_param: illegal DATA_W/PAT_W/CNT_W combination");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q,  word_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [PAT_W-1:0]  hist_q,  hist_d;
  logic [FIL_W-1:0]  fill_q,  fill_d;
  logic              found_q, found_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  pos_q,   pos_d;

  logic              bit_in;
  logic [PAT_W-1:0]  hist_new;
  logic [FIL_W-1:0]  fill_new;
  logic              hit;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    found_d = found_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;

    // Match is judged on the history with the current bit already shifted in.
    bit_in   = word_q[idx_q];
    hist_new = (hist_q << 1) | PAT_W'(bit_in);
    fill_new = (fill_q == FIL_W'(PAT_W)) ? fill_q : fill_q + FIL_W'(1);
    hit      = (fill_new == FIL_W'(PAT_W)) && (hist_new == PATTERN);

    if (start) begin
      // A restart beats everything, including the last bit of a running scan.
      state_d = SCAN;
      word_d  = data;
      idx_d   = IDX_W'(DATA_W - 1);
      hist_d  = '0;
      fill_d  = '0;
      found_d = 1'b0;
      cnt_d   = '0;
      pos_d   = '0;
    end else begin
      case (state_q)
        SCAN: begin
          hist_d = hist_new;
          fill_d = fill_new;
          idx_d  = idx_q - IDX_W'(1);
          if (hit) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (!found_q) begin
              found_d = 1'b1;
              pos_d   = idx_q;
            end
            if (!OVERLAP) begin
              hist_d = '0;
              fill_d = '0;
            end
          end
          if (idx_q == '0) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      found_q <= 1'b0;
      cnt_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
  end

  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign match_count = cnt_q;
  assign first_pos   = pos_q;

endmodule
